// File: rtl/reservation_station_if.sv
// Issue, CDB and functional-unit signal bundle for the reservation station.
// The master side drives the requests and the slave side is the station.
interface reservation_station_if;
  logic        in_enable;
  logic [5:0]  in_operator_type;
  logic [31:0] in_val_1;
  logic [31:0] in_val_2;
  logic [4:0]  in_tag_1;
  logic [4:0]  in_tag_2;
  logic [3:0]  in_ICC_flags;
  logic        in_CDB_broadcast;
  logic [4:0]  in_CDB_tag;
  logic [31:0] in_CDB_val;
  logic        in_fu_ready;
  logic        out_rs_enable;
  logic [4:0]  out_rs_tag;
  logic        out_full;
  logic        out_issue_drop;
  logic        out_fu_enable;
  logic [5:0]  out_fu_operator_type;
  logic [31:0] out_fu_val_1;
  logic [31:0] out_fu_val_2;
  logic [3:0]  out_fu_ICC_flags;
  logic [4:0]  out_fu_tag;

  modport master (
    output in_enable, in_operator_type,
    output in_val_1, in_val_2,
    output in_tag_1, in_tag_2,
    output in_ICC_flags,
    output in_CDB_broadcast, in_CDB_tag,
    output in_CDB_val, in_fu_ready,
    input  out_rs_enable, out_rs_tag,
    input  out_full, out_issue_drop,
    input  out_fu_enable, out_fu_operator_type,
    input  out_fu_val_1, out_fu_val_2,
    input  out_fu_ICC_flags, out_fu_tag
  );

  modport slave (
    input  in_enable, in_operator_type,
    input  in_val_1, in_val_2,
    input  in_tag_1, in_tag_2,
    input  in_ICC_flags,
    input  in_CDB_broadcast, in_CDB_tag,
    input  in_CDB_val, in_fu_ready,
    output out_rs_enable, out_rs_tag,
    output out_full, out_issue_drop,
    output out_fu_enable, out_fu_operator_type,
    output out_fu_val_1, out_fu_val_2,
    output out_fu_ICC_flags, out_fu_tag
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: issue allocation, CDB operand snooping, and
// in-order-by-index dispatch to a single functional unit.
module reservation_station #(
  parameter int          NUM_ENTRIES = 4,
  parameter int          TAG_BASE    = 0,
  parameter logic [4:0]  INVALID_TAG = 5'b11111
) (
  input logic                  clk,
  input logic                  rst,
  reservation_station_if.slave bus
);

  typedef enum logic [1:0] {
    FREE, WAITING, EXECUTING
  } state_t;

  state_t      st_q [NUM_ENTRIES];
  state_t      st_d [NUM_ENTRIES];
  logic [5:0]  op_q [NUM_ENTRIES];
  logic [5:0]  op_d [NUM_ENTRIES];
  logic [31:0] v1_q [NUM_ENTRIES];
  logic [31:0] v1_d [NUM_ENTRIES];
  logic [31:0] v2_q [NUM_ENTRIES];
  logic [31:0] v2_d [NUM_ENTRIES];
  logic [4:0]  t1_q [NUM_ENTRIES];
  logic [4:0]  t1_d [NUM_ENTRIES];
  logic [4:0]  t2_q [NUM_ENTRIES];
  logic [4:0]  t2_d [NUM_ENTRIES];
  logic [3:0]  cc_q [NUM_ENTRIES];
  logic [3:0]  cc_d [NUM_ENTRIES];

  logic        issue_ok;
  logic        cdb_ok;
  logic        alloc_hit;
  logic [2:0]  alloc_idx;
  logic        disp_hit;
  logic [2:0]  disp_idx;
  logic        disp_fire;
  logic        full_d;
  logic [5:0]  sel_op;
  logic [31:0] sel_v1;
  logic [31:0] sel_v2;
  logic [3:0]  sel_cc;

  always_comb begin
    st_d = st_q;
    op_d = op_q;
    v1_d = v1_q;
    v2_d = v2_q;
    t1_d = t1_q;
    t2_d = t2_q;
    cc_d = cc_q;
    alloc_hit = 1'b0;
    alloc_idx = 3'd0;
    disp_hit  = 1'b0;
    disp_idx  = 3'd0;
    sel_op = 6'd0;
    sel_v1 = 32'd0;
    sel_v2 = 32'd0;
    sel_cc = 4'd0;
    full_d = 1'b1;
    issue_ok = bus.in_enable && !bus.out_full;
    cdb_ok = bus.in_CDB_broadcast
          && (bus.in_CDB_tag != INVALID_TAG);

    // Descending scan leaves the lowest matching index selected.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        alloc_hit = 1'b1;
        alloc_idx = 3'(i);
      end
      if (st_q[i] == WAITING
          && t1_q[i] == INVALID_TAG
          && t2_q[i] == INVALID_TAG) begin
        disp_hit = 1'b1;
        disp_idx = 3'(i);
      end
    end
    disp_fire = disp_hit && bus.in_fu_ready;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cdb_ok && st_q[i] == WAITING) begin
        if (t1_q[i] == bus.in_CDB_tag) begin
          v1_d[i] = bus.in_CDB_val;
          t1_d[i] = INVALID_TAG;
        end
        if (t2_q[i] == bus.in_CDB_tag) begin
          v2_d[i] = bus.in_CDB_val;
          t2_d[i] = INVALID_TAG;
        end
      end
      if (cdb_ok && st_q[i] == EXECUTING
          && 5'(TAG_BASE + i) == bus.in_CDB_tag)
        st_d[i] = FREE;
      if (disp_fire && disp_idx == 3'(i)) begin
        st_d[i] = EXECUTING;
        sel_op = op_q[i];
        sel_v1 = v1_q[i];
        sel_v2 = v2_q[i];
        sel_cc = cc_q[i];
      end
      if (issue_ok && alloc_hit && alloc_idx == 3'(i)) begin
        st_d[i] = WAITING;
        op_d[i] = bus.in_operator_type;
        cc_d[i] = bus.in_ICC_flags;
        v1_d[i] = bus.in_val_1;
        t1_d[i] = bus.in_tag_1;
        v2_d[i] = bus.in_val_2;
        t2_d[i] = bus.in_tag_2;
        if (cdb_ok && bus.in_tag_1 == bus.in_CDB_tag) begin
          v1_d[i] = bus.in_CDB_val;
          t1_d[i] = INVALID_TAG;
        end
        if (cdb_ok && bus.in_tag_2 == bus.in_CDB_tag) begin
          v2_d[i] = bus.in_CDB_val;
          t2_d[i] = INVALID_TAG;
        end
      end
    end

    for (int i = 0; i < NUM_ENTRIES; i++)
      if (st_d[i] == FREE) full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st_q[i] <= FREE;
        op_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
        t1_q[i] <= INVALID_TAG;
        t2_q[i] <= INVALID_TAG;
        cc_q[i] <= '0;
      end
      bus.out_rs_enable        <= 1'b0;
      bus.out_rs_tag           <= INVALID_TAG;
      bus.out_full             <= 1'b0;
      bus.out_issue_drop       <= 1'b0;
      bus.out_fu_enable        <= 1'b0;
      bus.out_fu_operator_type <= '0;
      bus.out_fu_val_1         <= '0;
      bus.out_fu_val_2         <= '0;
      bus.out_fu_ICC_flags     <= '0;
      bus.out_fu_tag           <= INVALID_TAG;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      cc_q <= cc_d;
      bus.out_full       <= full_d;
      bus.out_issue_drop <= bus.in_enable && bus.out_full;
      bus.out_rs_enable  <= issue_ok && alloc_hit;
      if (issue_ok && alloc_hit)
        bus.out_rs_tag <= 5'(TAG_BASE) + 5'(alloc_idx);
      bus.out_fu_enable <= disp_fire;
      if (disp_fire) begin
        bus.out_fu_operator_type <= sel_op;
        bus.out_fu_val_1         <= sel_v1;
        bus.out_fu_val_2         <= sel_v2;
        bus.out_fu_ICC_flags     <= sel_cc;
        bus.out_fu_tag <= 5'(TAG_BASE) + 5'(disp_idx);
      end
    end
  end

endmodule
